// File: rtl/instr_fetch_queue.sv
// ----------------------------------------------------------------------------
// instr_fetch_queue
//   Circular-buffer instruction fetch queue between the fetch unit and the
//   instruction register. Words come out in strict FIFO order. A word pushed
//   into an empty queue becomes visible at the head after the same edge.
//   There is no bypass from in_data to out_data.
//
// Parameters
//   WIDTH     instruction word width in bits
//   DEPTH     number of entries; must be a power of two and at least 2
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-low reset. It clears the pointers, the
//             count and overflow.
//   in_valid  upstream presents a word on in_data
//   in_data   fetched instruction word
//   in_ready  queue can accept a word (cnt < DEPTH). Driven from registers only.
//   out_valid head entry valid (cnt != 0). Drives the enable of the
//             instruction register.
//   out_data  head entry mem[rp]. Drives d of the instruction register.
//   out_ready downstream consumes the head this cycle
//   flush     discard all queued words on a branch redirect
//   count     number of valid entries
//   overflow  sticky flag: a push was attempted while the queue was full
// ----------------------------------------------------------------------------
module instr_fetch_queue #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_cnt;
  logic             r_overflow;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  always_comb begin
    w_full  = (r_cnt == FULL_CNT);
    w_empty = (r_cnt == '0);
    // A flush cycle performs neither a push nor a pop.
    w_push  = in_valid  & ~w_full  & ~flush;
    w_pop   = out_ready & ~w_empty & ~flush;
  end

  assign in_ready  = ~w_full;
  assign out_valid = ~w_empty;
  assign out_data  = r_mem[r_rp];
  assign count     = r_cnt;
  assign overflow  = r_overflow;

  // Storage is not reset. Entries are only ever read while counted valid.
  always_ff @(posedge clk) begin
    if (reset && w_push) begin
      r_mem[r_wp] <= in_data;
    end
  end

  // The pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (in_valid && w_full) begin
        r_overflow <= 1'b1;
      end
      if (w_push) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter WIDTH, default 32, instruction word width in bits.
REQ-002 Parameter DEPTH, default 4, number of queue entries; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; reset=0 sampled at a rising clk edge clears all state.
REQ-005 in_valid  input  1  upstream fetch presents a word on in_data.
REQ-006 in_data  input  WIDTH  fetched instruction word.
REQ-007 in_ready  output  1  queue can accept a word this cycle.
REQ-008 out_valid  output  1  head entry valid; drives the enable of the downstream instruction-register FLOPENR.
REQ-009 out_data  output  WIDTH  head entry; drives the d input of the downstream instruction register.
REQ-010 out_ready  input  1  downstream stage consumes the head this cycle.
REQ-011 flush  input  1  discard all queued words (branch redirect).
REQ-012 count  output  $clog2(DEPTH)+1  number of valid entries.
REQ-013 overflow  output  1  sticky flag, push attempted while full.

Function
REQ-014 Storage SHALL be a circular buffer with write pointer wp, read pointer rp, and occupancy counter cnt; pointers wrap modulo DEPTH.
REQ-015 in_ready SHALL equal (cnt < DEPTH), derived from registered state only, with no combinational path from out_ready.
REQ-016 out_valid SHALL equal (cnt != 0); out_data SHALL equal mem[rp] combinationally.
REQ-017 push = in_valid & in_ready; pop = out_valid & out_ready.
REQ-018 Push only: mem[wp] <= in_data, wp++, cnt++.
REQ-019 Pop only: rp++, cnt--.
REQ-020 Push and pop in the same cycle: both pointers advance and cnt is unchanged; when full, no push occurs because in_ready=0.
REQ-021 Latency: a word pushed at edge N SHALL appear on out_data with out_valid=1 after edge N when the queue was empty; there is no same-cycle bypass.
REQ-022 Order SHALL be strict FIFO; no word is duplicated or lost except on flush or reset.
REQ-023 flush=1 at an edge SHALL set wp=rp=0 and cnt=0 and ignore any push or pop in that cycle; out_valid=0 after that edge.
REQ-024 in_valid=1 while cnt==DEPTH SHALL set overflow=1; the word is dropped and the queue is unchanged.
REQ-025 out_ready=1 while empty SHALL be ignored; no pointer or counter change.
REQ-026 count SHALL equal cnt at all times.

Reset
REQ-027 reset=0 at an edge SHALL force wp=0, rp=0, cnt=0, overflow=0; this takes priority over flush, push and pop.
REQ-028 After reset: in_ready=1, out_valid=0, count=0, overflow=0; out_data is don't-care.
REQ-029 Reset asserted mid-operation SHALL discard all entries; the first push after release is the first word output.
REQ-030 Memory contents need not be cleared by reset.

Verification
REQ-031 Push 0x11,0x22,0x33,0x44 with out_ready=0 -> count=4, in_ready=0; then out_ready=1 for 4 cycles -> out_data sequence 0x11,0x22,0x33,0x44, then out_valid=0.
REQ-032 Full queue, in_valid=1 with 0x55, out_ready=0 -> overflow=1, count=4, drained order excludes 0x55.
REQ-033 count=2, push 0xAA and pop in the same cycle -> count stays 2, pointers wrap correctly across 2xDEPTH such cycles, FIFO order preserved.
REQ-034 count=3, flush=1 together with in_valid=1 and out_ready=1 -> count=0, out_valid=0, next push 0x77 appears as head.
REQ-035 count=3, overflow=1, reset=0 for one edge -> count=0, overflow=0, in_ready=1; push 0x99 -> out_data=0x99 next cycle.
REQ-036 Connect out_valid and out_data to FLOPENR en and d, pop every cycle -> the instruction register holds each word for exactly one cycle, in order.
